// File: rtl/uart_echo_fifo_if.sv
// Handshake bundle between the UART receiver/transmitter and the echo FIFO.
// drop_cnt exists only when UART_ECHO_FIFO_DROPCNT_EN is defined.
interface uart_echo_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  logic                     wr_valid;
  logic [DATA_W-1:0]        wr_data;
  logic                     rd_valid;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_ready;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     clr_ovf;
`ifdef UART_ECHO_FIFO_DROPCNT_EN
  logic [7:0]               drop_cnt;
`endif

  modport master (
    output wr_valid, wr_data, rd_ready, clr_ovf,
`ifdef UART_ECHO_FIFO_DROPCNT_EN
    input  drop_cnt,
`endif
    input  rd_valid, rd_data, full, empty, count, overflow
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready, clr_ovf,
`ifdef UART_ECHO_FIFO_DROPCNT_EN
    output drop_cnt,
`endif
    output rd_valid, rd_data, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// First-word-fall-through byte FIFO absorbing UART RX bytes while TX is busy.
// Optional saturating drop counter enabled by UART_ECHO_FIFO_DROPCNT_EN.
module uart_echo_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_echo_fifo_if.slave   bus
);
  // state   | meaning (implicit, derived from count)
  // EMPTY   | count == 0, rd_valid low
  // PARTIAL | 0 < count < DEPTH
  // FULL    | count == DEPTH, writes drop unless a read fires
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     count_q;
  logic              overflow_q;
  logic              full;
  logic              empty;
  logic              rd_fire;
  logic              wr_acc;
  logic              drop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_fire = !empty && bus.rd_ready;
  assign wr_acc  = bus.wr_valid && (!full || rd_fire);
  assign drop    = bus.wr_valid && full && !rd_fire;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.rd_valid = !empty;
  assign bus.rd_data  = mem[rp];
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

  // Storage is intentionally left unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp         <= '0;
      rp         <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_acc)  wp <= wp + 1'b1;
      if (rd_fire) rp <= rp + 1'b1;
      if (wr_acc && !rd_fire)      count_q <= count_q + 1'b1;
      else if (rd_fire && !wr_acc) count_q <= count_q - 1'b1;
      if (drop)             overflow_q <= 1'b1;
      else if (bus.clr_ovf) overflow_q <= 1'b0;
    end
  end

`ifdef UART_ECHO_FIFO_DROPCNT_EN
  logic [7:0] drop_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (bus.clr_ovf) begin
      drop_cnt_q <= drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed self-checking bench for uart_echo_fifo (DEPTH=16, DATA_W=8).
// Drop-counter checks are compiled in with UART_ECHO_FIFO_DROPCNT_EN.
module tb_uart_echo_fifo;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  uart_echo_fifo_if #(.DEPTH(16), .DATA_W(8)) bus ();

  uart_echo_fifo #(.DEPTH(16), .DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_data = 8'h00; bus.rd_ready = 1'b0; bus.clr_ovf = 1'b0;
    #12;
    reset_n = 1'b1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
`ifdef UART_ECHO_FIFO_DROPCNT_EN
    checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
`endif
  endtask

  task automatic test_single();
    repeat (8) tick();
    bus.wr_valid = 1'b1; bus.wr_data = 8'hAA;
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL single_rd_valid: got %b want 1", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'hAA) begin errors++; $display("FAIL single_rd_data: got %h want aa", bus.rd_data); end
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.count); end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", bus.empty); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL single_count_after: got %0d want 0", bus.count); end
  endtask

  task automatic test_burst();
    logic [7:0] vec [4];
    vec[0] = 8'hAA; vec[1] = 8'h9D; vec[2] = 8'h01; vec[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = vec[i];
      tick();
    end
    bus.wr_valid = 1'b0;
    checks++; if (bus.count !== 5'd4) begin errors++; $display("FAIL burst_count: got %0d want 4", bus.count); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== vec[i]) begin
        errors++; $display("FAIL burst_data[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, vec[i]);
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL burst_drained: got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 8'(i);
      tick();
    end
    bus.wr_valid = 1'b0;
    checks++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_full: got full=%b ovf=%b want 1 0", bus.full, bus.overflow); end
    bus.wr_valid = 1'b1; bus.wr_data = 8'h55;
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL drop_full: got %b want 1", bus.full); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b want 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL drop_count: got %0d want 16", bus.count); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL drop_head: got %h want 00", bus.rd_data); end
`ifdef UART_ECHO_FIFO_DROPCNT_EN
    checks++; if (bus.drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt_one: got %0d want 1", bus.drop_cnt); end
`endif
    // Drop coincident with clear: set wins, counter restarts at 1.
    bus.wr_valid = 1'b1; bus.wr_data = 8'h66; bus.clr_ovf = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.clr_ovf = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drop_clr_overflow: got %b want 1", bus.overflow); end
`ifdef UART_ECHO_FIFO_DROPCNT_EN
    checks++; if (bus.drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_clr_cnt: got %0d want 1", bus.drop_cnt); end
`endif
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b want 0", bus.overflow); end
`ifdef UART_ECHO_FIFO_DROPCNT_EN
    checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_drop_cnt: got %0d want 0", bus.drop_cnt); end
`endif
  endtask

  task automatic test_full_rw();
    logic [7:0] exp;
    bus.wr_valid = 1'b1; bus.wr_data = 8'h77; bus.rd_ready = 1'b1;
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL full_rw_read: got %h want 00", bus.rd_data); end
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL full_rw_count: got %0d want 16", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_rw_overflow: got %b want 0", bus.overflow); end
    for (int i = 1; i <= 16; i++) begin
      exp = (i == 16) ? 8'h77 : 8'(i);
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
        errors++; $display("FAIL full_rw_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp);
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [7:0] prev;
    prev = 8'h00;
    for (int i = 0; i < 20; i++) begin
      b = 8'(8'hC0 + 8'(i * 3));
      bus.wr_valid = 1'b1; bus.wr_data = b; bus.rd_ready = 1'b1;
      if (i > 0) begin
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== prev) begin
          errors++; $display("FAIL b2b_data[%0d]: got v=%b d=%h want v=1 d=%h", i - 1, bus.rd_valid, bus.rd_data, prev);
        end
      end
      tick();
      checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, bus.count); end
      prev = b;
    end
    bus.wr_valid = 1'b0;
    checks++; if (bus.rd_data !== prev) begin errors++; $display("FAIL b2b_last: got %h want %h", bus.rd_data, prev); end
    tick();
    bus.rd_ready = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1; bus.wr_data = 8'(8'h10 + i);
      tick();
    end
    bus.wr_valid = 1'b0;
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL mid_pre_count: got %0d want 5", bus.count); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL mid_async_reset: got v=%b cnt=%0d e=%b want 0 0 1", bus.rd_valid, bus.count, bus.empty);
    end
    tick();
    #2 reset_n = 1'b1;
    tick();
    bus.wr_valid = 1'b1; bus.wr_data = 8'h3C;
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C || bus.count !== 5'd1) begin
      errors++; $display("FAIL mid_after: got v=%b d=%h cnt=%0d want 1 3c 1", bus.rd_valid, bus.rd_data, bus.count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_rw();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Byte FIFO between the UART receiver and transmitter inside the echo top level. It absorbs received bytes while the transmitter is busy, so back-to-back frames arriving at full baud are not lost. The write side takes single-cycle byte strobes from the receiver and has no backpressure. The read side presents first-word-fall-through data to the transmitter under a valid/ready handshake.

## Interface
- DEPTH, 16, number of byte entries; power of two, ≥ 2
- DATA_W, 8, entry width in bits
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- wr_valid  input  1  one-cycle strobe: wr_data holds a received byte
- wr_data  input  DATA_W  received byte
- rd_valid  output  1  rd_data holds the oldest stored entry
- rd_data  output  DATA_W  oldest entry (first-word fall-through)
- rd_ready  input  1  transmitter accepts rd_data this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was dropped
- clr_ovf  input  1  one-cycle clear of overflow
- drop_cnt  output  8  dropped-byte counter; present only with UART_ECHO_FIFO_DROPCNT_EN

## Operation
- Storage: DEPTH×DATA_W register array; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH. The count register tracks occupancy; full and empty derive combinationally from count.
- Write accepted: wr_valid && (!full || rd_fire). mem[wp] ← wr_data, then wp+1.
- Read fire: rd_fire = rd_valid && rd_ready, then rp+1.
- rd_valid = !empty. rd_data = mem[rp], combinational from the registered array and rp. rd_data is don't-care when empty.
- count: +1 on an accepted write without a read fire; −1 on a read fire without a write; unchanged when both or neither occur.
- Simultaneous write and read while full: read frees a slot and the write is accepted. count stays DEPTH and no drop occurs.
- Simultaneous write and read-ready while empty: rd_valid=0, so there is no read fire. The write is accepted and count goes to 1.
- Drop: wr_valid && full && !rd_fire. Data is discarded, pointers and count are unchanged, and overflow←1.
- overflow: set by a drop and cleared by clr_ovf. If a drop and clr_ovf occur in the same cycle, set wins.
- rd_ready while rd_valid=0 has no effect. wr_valid is sampled every cycle it is high; each high cycle is one byte.
- The state machine is implicit: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
  - EMPTY→PARTIAL on a write.
  - PARTIAL→FULL when count reaches DEPTH.
  - FULL→PARTIAL on a read fire without a write.
  - PARTIAL→EMPTY when the last entry is read.

## Timing
- Reset values (asynchronous assert, synchronous to clk on deassert):
  - wp = rp = 0, count = 0
  - empty = 1, full = 0, rd_valid = 0, overflow = 0, drop_cnt = 0
  - Array contents are not reset.
- Write to read latency: a byte written at edge N makes rd_valid = 1 and rd_data = that byte in the cycle after edge N, if the FIFO was empty.
- A read fire at edge N presents the next entry, or rd_valid=0, in the cycle after edge N.
- Sustained throughput: one write and one read per cycle.
- count, full, empty and overflow update on the same edge as the event that changes them.
- Reset asserted mid-operation: immediate return to the reset state and all stored bytes are discarded. The transmitter sees rd_valid fall asynchronously.

## Configuration
- UART_ECHO_FIFO_DROPCNT_EN defined:
  - The drop_cnt port exists.
  - It increments on each drop and saturates at 255.
  - It is cleared by reset and by clr_ovf; if a drop and clr_ovf occur in the same cycle, the result is 1.
- Not defined: the drop_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then write 0xAA at cycle 10 -> rd_valid=1, rd_data=0xAA from cycle 11; count=1. Assert rd_ready one cycle -> empty=1, count=0.
- Write 0xAA, then 0x9D, 0x01, 0xFF on consecutive cycles, with rd_ready held low -> count=4. Then rd_ready=1 continuously -> data out in order 0xAA, 0x9D, 0x01, 0xFF, one per cycle, then rd_valid=0.
- Fill DEPTH=16 with 0x00..0x0F, then write 0x55 with rd_ready=0 -> full=1, overflow=1, count=16, 0x55 absent. With the macro defined, drop_cnt=1. Pulse clr_ovf -> overflow=0 and drop_cnt=0.
- Full FIFO, write 0x77 and rd_ready=1 in the same cycle -> 0x00 read, 0x77 accepted, count=16, overflow=0. Drain -> 0x01..0x0F, 0x77.
- Write 20 bytes with wr_valid and rd_ready both high every cycle -> all 20 bytes emerge in order, count ≤ 1, and pointers wrap past 15 correctly.
- Write 5 bytes, then pulse reset_n low mid-stream -> rd_valid=0, count=0, empty=1 asynchronously. After release, write 0x3C -> rd_data=0x3C.
